// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion sequencer.
// Walks the round index and fetches SubWord results from the shared S-box over a
// req/ack handshake. It drives the combinational aes_key_xor block and streams round
// keys to the cipher core over valid/ready. Supports AES-128 (mode 00) and AES-256 (mode 10).
// Optional feature macro: AES_KEY_SCHED_CACHE_EN adds a 15-entry round-key store and a
// replay_i input that re-streams the stored keys without touching the S-box or XOR block.

module aes_key_sched_ctrl #(
  parameter int BOX_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   mode_i,
  input  logic [255:0] key_i,
`ifdef AES_KEY_SCHED_CACHE_EN
  input  logic         replay_i,
`endif
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         box_req_o,
  output logic         box_rot_o,
  output logic [31:0]  box_word_o,
  input  logic         box_ack_i,
  input  logic [31:0]  box_word_i,
  output logic [3:0]   xor_rd_o,
  output logic [1:0]   xor_mode_o,
  output logic [31:0]  xor_word_o,
  output logic [127:0] xor_old_key_o,
  input  logic [127:0] xor_new_key_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [3:0]   rk_idx_o,
  output logic [127:0] rk_o
);

  localparam int CNT_W = $clog2(BOX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EMIT,
    S_BOXREQ,
    S_XOR,
    S_DONE,
    S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [255:0]   key_q, key_d;
  logic [3:0]     idx_q, idx_d;
  // rkCur holds rk[idx] (the key being emitted), rkPrev holds rk[idx-1].
  // Right after LOAD rkPrev parks key[127:0] so AES-256 can emit it as rk1.
  logic [127:0]   rkCur_q, rkCur_d;
  logic [127:0]   rkPrev_q, rkPrev_d;
  logic [3:0]     xorRd_q, xorRd_d;
  logic [31:0]    xorWord_q, xorWord_d;
  logic [127:0]   xorOld_q, xorOld_d;
  logic [CNT_W-1:0] boxCnt_q, boxCnt_d;

  logic           is256;
  logic [3:0]     lastIdx;
  logic           modeOk;

`ifdef AES_KEY_SCHED_CACHE_EN
  logic [127:0]   store_q [15];
  logic           storeWe;
  logic           cacheValid_q, cacheValid_d;
  logic           replay_q, replay_d;
`endif

  assign is256   = mode_q[1];
  assign lastIdx = is256 ? 4'd14 : 4'd10;
  assign modeOk  = (mode_i == 2'b00) || (mode_i == 2'b10);

  assign xor_rd_o      = xorRd_q;
  assign xor_mode_o    = mode_q;
  assign xor_word_o    = xorWord_q;
  assign xor_old_key_o = xorOld_q;
  assign rk_idx_o      = idx_q;

`ifdef AES_KEY_SCHED_CACHE_EN
  assign rk_o = replay_q ? store_q[idx_q] : rkCur_q;
`else
  assign rk_o = rkCur_q;
`endif

  // FSM state register; reset drops any run in progress immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: captured mode/key, round-key history and the held XOR inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= 2'b00;
      key_q     <= '0;
      idx_q     <= '0;
      rkCur_q   <= '0;
      rkPrev_q  <= '0;
      xorRd_q   <= '0;
      xorWord_q <= '0;
      xorOld_q  <= '0;
      boxCnt_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      rkCur_q   <= rkCur_d;
      rkPrev_q  <= rkPrev_d;
      xorRd_q   <= xorRd_d;
      xorWord_q <= xorWord_d;
      xorOld_q  <= xorOld_d;
      boxCnt_q  <= boxCnt_d;
    end
  end

`ifdef AES_KEY_SCHED_CACHE_EN
  // Cache bookkeeping: validity of the stored stream and whether EMIT is replaying it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cacheValid_q <= 1'b0;
      replay_q     <= 1'b0;
    end else begin
      cacheValid_q <= cacheValid_d;
      replay_q     <= replay_d;
    end
  end

  // Round-key store, written with each freshly generated key as the consumer accepts it.
  always_ff @(posedge clk) begin
    if (storeWe) begin
      store_q[idx_q] <= rkCur_q;
    end
  end
`endif

  // Next-state and Moore outputs; every register holds unless a state updates it.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    idx_d      = idx_q;
    rkCur_d    = rkCur_q;
    rkPrev_d   = rkPrev_q;
    xorRd_d    = xorRd_q;
    xorWord_d  = xorWord_q;
    xorOld_d   = xorOld_q;
    boxCnt_d   = boxCnt_q;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    err_o      = 1'b0;
    box_req_o  = 1'b0;
    box_rot_o  = 1'b0;
    box_word_o = '0;
    rk_valid_o = 1'b0;
`ifdef AES_KEY_SCHED_CACHE_EN
    storeWe      = 1'b0;
    cacheValid_d = cacheValid_q;
    replay_d     = replay_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef AES_KEY_SCHED_CACHE_EN
          cacheValid_d = 1'b0;
`endif
          if (modeOk) begin
            mode_d  = mode_i;
            key_d   = key_i;
            state_d = S_LOAD;
          end else begin
            state_d = S_ERR;
          end
        end
`ifdef AES_KEY_SCHED_CACHE_EN
        else if (replay_i) begin
          if (cacheValid_q) begin
            replay_d = 1'b1;
            idx_d    = 4'd0;
            state_d  = S_EMIT;
          end else begin
            state_d = S_ERR;
          end
        end
`endif
      end

      S_LOAD: begin
        busy_o   = 1'b1;
        rkCur_d  = key_q[255:128];
        rkPrev_d = key_q[127:0];
        idx_d    = 4'd0;
        state_d  = S_EMIT;
      end

      S_EMIT: begin
        busy_o     = 1'b1;
        rk_valid_o = 1'b1;
        if (rk_ready_i) begin
`ifdef AES_KEY_SCHED_CACHE_EN
          storeWe = !replay_q;
`endif
          if (idx_q == lastIdx) begin
            state_d = S_DONE;
          end
`ifdef AES_KEY_SCHED_CACHE_EN
          else if (replay_q) begin
            idx_d = idx_q + 4'd1;
          end
`endif
          else if (is256 && (idx_q == 4'd0)) begin
            rkCur_d  = rkPrev_q;
            rkPrev_d = rkCur_q;
            idx_d    = 4'd1;
          end else begin
            boxCnt_d = '0;
            state_d  = S_BOXREQ;
          end
        end
      end

      S_BOXREQ: begin
        busy_o     = 1'b1;
        box_req_o  = 1'b1;
        box_word_o = rkCur_q[31:0];
        box_rot_o  = !is256 || idx_q[0];
        if (box_ack_i) begin
          xorWord_d = box_word_i;
          xorRd_d   = idx_q + 4'd1;
          xorOld_d  = is256 ? rkPrev_q : rkCur_q;
          state_d   = S_XOR;
        end else if (boxCnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end else begin
          boxCnt_d = boxCnt_q + CNT_W'(1);
        end
      end

      S_XOR: begin
        busy_o   = 1'b1;
        rkPrev_d = rkCur_q;
        rkCur_d  = xor_new_key_i;
        idx_d    = xorRd_q;
        state_d  = S_EMIT;
      end

      S_DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = S_IDLE;
`ifdef AES_KEY_SCHED_CACHE_EN
        cacheValid_d = 1'b1;
        replay_d     = 1'b0;
`endif
      end

      S_ERR: begin
        err_o   = 1'b1;
        state_d = S_IDLE;
`ifdef AES_KEY_SCHED_CACHE_EN
        replay_d = 1'b0;
`endif
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl. Plays the S-box and aes_key_xor neighbours.
// Checks FIPS-197 A.1/A.3 streams, stalls, box timeout, illegal mode and mid-run reset.

module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [1:0]   mode_i;
  logic [255:0] key_i;
  logic         busy_o, done_o, err_o;
  logic         box_req_o, box_rot_o;
  logic [31:0]  box_word_o;
  logic         box_ack_i;
  logic [31:0]  box_word_i;
  logic [3:0]   xor_rd_o;
  logic [1:0]   xor_mode_o;
  logic [31:0]  xor_word_o;
  logic [127:0] xor_old_key_o;
  logic [127:0] xor_new_key_i;
  logic         rk_valid_o;
  logic         rk_ready_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_o;

  localparam logic [255:0] KEY_A1 =
    256'h2b7e151628aed2a6abf7158809cf4f3c_deadbeef0123456789abcdeffedcba98;
  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  int           vectors = 0;
  int           miscompares = 0;
  int           nKeys, nReq, doneCnt, errCnt, reqCycles;
  bit           idxOk, stableOk, streamOk, sawValid;
  logic [15:0]  rotBits;
  logic [127:0] keys [16];
  logic [127:0] expKeys [16];
  int           firstValid [16];

  aes_key_sched_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .key_i         (key_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .box_req_o     (box_req_o),
    .box_rot_o     (box_rot_o),
    .box_word_o    (box_word_o),
    .box_ack_i     (box_ack_i),
    .box_word_i    (box_word_i),
    .xor_rd_o      (xor_rd_o),
    .xor_mode_o    (xor_mode_o),
    .xor_word_o    (xor_word_o),
    .xor_old_key_o (xor_old_key_o),
    .xor_new_key_i (xor_new_key_i),
    .rk_valid_o    (rk_valid_o),
    .rk_ready_i    (rk_ready_i),
    .rk_idx_o      (rk_idx_o),
    .rk_o          (rk_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    case (j)
      1: return 8'h01;
      2: return 8'h02;
      3: return 8'h04;
      4: return 8'h08;
      5: return 8'h10;
      6: return 8'h20;
      7: return 8'h40;
      8: return 8'h80;
      9: return 8'h1b;
      10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Behaviour of the external aes_key_xor block.
  function automatic logic [127:0] keyXor(input logic [3:0] rd, input logic [1:0] md,
                                          input logic [31:0] sw, input logic [127:0] old);
    logic [7:0]  rc;
    logic [31:0] w0, w1, w2, w3;
    if (md == 2'b10) rc = rd[0] ? 8'h00 : rcon(int'(rd) / 2);
    else             rc = rcon(int'(rd));
    w0 = old[127:96] ^ sw ^ {rc, 24'h0};
    w1 = old[95:64] ^ w0;
    w2 = old[63:32] ^ w1;
    w3 = old[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign xor_new_key_i = keyXor(xor_rd_o, xor_mode_o, xor_word_o, xor_old_key_o);

  task automatic buildExpected(input logic [1:0] md, input logic [255:0] key);
    logic [31:0] w;
    for (int i = 0; i < 16; i++) expKeys[i] = '0;
    expKeys[0] = key[255:128];
    if (md == 2'b10) begin
      expKeys[1] = key[127:0];
      for (int i = 2; i < 15; i++) begin
        w = expKeys[i-1][31:0];
        if (i % 2 == 0) w = rotWord(w);
        expKeys[i] = keyXor(4'(i), md, subWord(w), expKeys[i-2]);
      end
    end else begin
      for (int i = 1; i < 11; i++) begin
        w = rotWord(expKeys[i-1][31:0]);
        expKeys[i] = keyXor(4'(i), md, subWord(w), expKeys[i-1]);
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One expansion run: start, then act as S-box and consumer until done/err/limit.
  task automatic applyStimulus(input logic [1:0] mode, input logic [255:0] key, input bit randStall,
                               input bit neverAck, input bit holdStart, input int maxKeys);
    int          cyc, reqAge, ackDelay;
    bit          stalled, prevReq;
    logic [127:0] heldKey;
    logic [3:0]  heldIdx;
    logic [31:0] w;
    nKeys = 0; nReq = 0; doneCnt = 0; errCnt = 0; reqCycles = 0;
    idxOk = 1'b1; stableOk = 1'b1; rotBits = '0;
    for (int i = 0; i < 16; i++) begin
      keys[i] = '0;
      firstValid[i] = -1;
    end
    stalled = 1'b0; prevReq = 1'b0; reqAge = 0; ackDelay = 0;
    heldKey = '0; heldIdx = '0;
    @(negedge clk);
    mode_i = mode; key_i = key; start_i = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      box_ack_i = 1'b0;
      rk_ready_i = 1'b0;
      if (holdStart) begin
        mode_i = 2'b01;
        key_i = ~key;
      end else begin
        start_i = 1'b0;
      end
      if (nKeys >= maxKeys) break;
      if (done_o) begin doneCnt++; start_i = 1'b0; break; end
      if (err_o) begin errCnt++; start_i = 1'b0; break; end
      if (box_req_o) begin
        if (!prevReq) begin
          rotBits[nReq] = box_rot_o;
          nReq++;
          reqAge = 0;
          ackDelay = neverAck ? 100000 : (randStall ? int'($urandom_range(20, 0)) : 0);
        end
        reqCycles++;
        if (reqAge == ackDelay) begin
          w = box_rot_o ? rotWord(box_word_o) : box_word_o;
          box_word_i = subWord(w);
          box_ack_i = 1'b1;
        end
        reqAge++;
      end
      prevReq = box_req_o;
      if (stalled && !rk_valid_o) stableOk = 1'b0;
      if (rk_valid_o) begin
        if (stalled) begin
          if (rk_o !== heldKey || rk_idx_o !== heldIdx) stableOk = 1'b0;
        end else begin
          firstValid[nKeys] = cyc;
        end
        rk_ready_i = randStall ? 1'($urandom_range(1, 0)) : 1'b1;
        if (rk_ready_i) begin
          keys[nKeys] = rk_o;
          if (rk_idx_o !== 4'(nKeys)) idxOk = 1'b0;
          nKeys++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          heldKey = rk_o;
          heldIdx = rk_idx_o;
        end
      end
    end
    rk_ready_i = 1'b0;
    box_ack_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic checkStream(input string tag, input int count);
    streamOk = 1'b1;
    for (int k = 0; k < count; k++) if (keys[k] !== expKeys[k]) streamOk = 1'b0;
    checkOutput(tag, 256'(streamOk), 256'(1));
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; mode_i = 2'b00; key_i = '0;
    box_ack_i = 1'b0; box_word_i = '0; rk_ready_i = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_ctrl", 256'({busy_o, done_o, err_o, box_req_o, box_rot_o, rk_valid_o}), 256'(0));
    checkOutput("reset_rk", 256'({rk_idx_o, rk_o}), 256'(0));
    checkOutput("reset_xor", 256'({xor_rd_o, xor_mode_o, xor_word_o, box_word_o}), 256'(0));
    checkOutput("reset_old", 256'(xor_old_key_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 A.1, zero-wait.
    $display("[TB] AES-128 A.1 zero-wait");
    buildExpected(2'b00, KEY_A1);
    applyStimulus(2'b00, KEY_A1, 1'b0, 1'b0, 1'b0, 99);
    checkOutput("a1_done", 256'(doneCnt), 256'(1));
    checkOutput("a1_nkeys", 256'(nKeys), 256'(11));
    checkOutput("a1_rk0", 256'(keys[0]), 256'(128'h2b7e151628aed2a6abf7158809cf4f3c));
    checkOutput("a1_rk1", 256'(keys[1]), 256'(128'ha0fafe1788542cb123a339392a6c7605));
    checkOutput("a1_rk10", 256'(keys[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    checkStream("a1_stream", 11);
    checkOutput("a1_idx", 256'(idxOk), 256'(1));
    checkOutput("a1_nreq", 256'(nReq), 256'(10));
    checkOutput("a1_rot", 256'(rotBits), 256'(16'h03ff));
    checkOutput("a1_lat0", 256'(firstValid[0]), 256'(2));
    checkOutput("a1_lat1", 256'(firstValid[1] - firstValid[0]), 256'(3));
    @(negedge clk);
    checkOutput("a1_after_done", 256'({busy_o, done_o, rk_valid_o}), 256'(0));

    // FIPS-197 A.3, zero-wait.
    $display("[TB] AES-256 A.3 zero-wait");
    buildExpected(2'b10, KEY_A3);
    applyStimulus(2'b10, KEY_A3, 1'b0, 1'b0, 1'b0, 99);
    checkOutput("a3_done", 256'(doneCnt), 256'(1));
    checkOutput("a3_nkeys", 256'(nKeys), 256'(15));
    checkOutput("a3_rk1", 256'(keys[1]), 256'(KEY_A3[127:0]));
    checkOutput("a3_rk2", 256'(keys[2]), 256'(128'h9ba354118e6925afa51a8b5f2067fcde));
    checkOutput("a3_rk14", 256'(keys[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));
    checkStream("a3_stream", 15);
    checkOutput("a3_idx", 256'(idxOk), 256'(1));
    checkOutput("a3_nreq", 256'(nReq), 256'(13));
    checkOutput("a3_rot", 256'(rotBits), 256'(16'h1555));
    checkOutput("a3_lat1", 256'(firstValid[1] - firstValid[0]), 256'(1));
    @(negedge clk);

    // A.3 with random consumer stalls and box ack delays.
    $display("[TB] AES-256 random stalls");
    applyStimulus(2'b10, KEY_A3, 1'b1, 1'b0, 1'b0, 99);
    checkOutput("a3r_done", 256'(doneCnt), 256'(1));
    checkOutput("a3r_nkeys", 256'(nKeys), 256'(15));
    checkOutput("a3r_stable", 256'(stableOk), 256'(1));
    checkStream("a3r_stream", 15);
    @(negedge clk);

    // A.1 with random stalls while start_i stays high with an illegal mode and other key.
    $display("[TB] AES-128 random stalls, start held while busy");
    buildExpected(2'b00, KEY_A1);
    applyStimulus(2'b00, KEY_A1, 1'b1, 1'b0, 1'b1, 99);
    checkOutput("hold_done", 256'(doneCnt), 256'(1));
    checkOutput("hold_err", 256'(errCnt), 256'(0));
    checkOutput("hold_nkeys", 256'(nKeys), 256'(11));
    checkOutput("hold_stable", 256'(stableOk), 256'(1));
    checkStream("hold_stream", 11);
    @(negedge clk);

    // S-box never answers.
    $display("[TB] box timeout");
    applyStimulus(2'b00, KEY_A1, 1'b0, 1'b1, 1'b0, 99);
    checkOutput("to_err", 256'(errCnt), 256'(1));
    checkOutput("to_reqcycles", 256'(reqCycles), 256'(64));
    checkOutput("to_nkeys", 256'(nKeys), 256'(1));
    checkOutput("to_busy", 256'({busy_o, box_req_o, done_o}), 256'(0));
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rk_valid_o || busy_o || err_o) sawValid = 1'b1;
    end
    checkOutput("to_quiet", 256'(sawValid), 256'(0));

    // Illegal modes.
    $display("[TB] illegal modes");
    for (int m = 1; m < 4; m += 2) begin
      @(negedge clk);
      start_i = 1'b1; mode_i = 2'(m); key_i = KEY_A1;
      @(negedge clk);
      start_i = 1'b0;
      checkOutput($sformatf("ill%0d_err", m), 256'({err_o, busy_o, rk_valid_o}), 256'(3'b100));
      @(negedge clk);
      checkOutput($sformatf("ill%0d_after", m), 256'({err_o, busy_o, rk_valid_o}), 256'(0));
    end

    // Reset in the middle of generating key 5, then a full clean run.
    $display("[TB] mid-run reset");
    applyStimulus(2'b00, KEY_A1, 1'b0, 1'b0, 1'b0, 5);
    checkOutput("mr_pre_req", 256'({busy_o, box_req_o}), 256'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_ctrl", 256'({busy_o, done_o, err_o, box_req_o, box_rot_o, rk_valid_o}), 256'(0));
    checkOutput("mr_rk", 256'({rk_idx_o, rk_o}), 256'(0));
    checkOutput("mr_xor", 256'({xor_rd_o, xor_mode_o, xor_word_o, box_word_o}), 256'(0));
    checkOutput("mr_old", 256'(xor_old_key_o), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b00, KEY_A1, 1'b0, 1'b0, 1'b0, 99);
    checkOutput("mr_done", 256'(doneCnt), 256'(1));
    checkOutput("mr_nkeys", 256'(nKeys), 256'(11));
    checkOutput("mr_rk10", 256'(keys[10]), 256'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    checkStream("mr_stream", 11);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
